// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle: valid/ready request side,
// registered result side with a one-cycle out_valid pulse.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] F;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             ZF;
    logic             CF;
    logic             OF;
    logic             SF;
    logic             PF;
    logic             DZ;

    modport master (
        output in_valid, OP, A, B,
        input  in_ready, out_valid, F, HI, LO,
        input  ZF, CF, OF, SF, PF, DZ
    );

    modport slave (
        input  in_valid, OP, A, B,
        output in_ready, out_valid, F, HI, LO,
        output ZF, CF, OF, SF, PF, DZ
    );
endinterface

// File: rtl/seq_alu.sv
// Clocked EX-stage ALU with iterative MUL/DIV into HI/LO.
// Define SEQ_ALU_SIGNED_MULDIV_EN to enable signed MULT/DIV (OP 13/14).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    seq_alu_if.slave bus
);
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_SLTU  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULT  = 4'd13;
    localparam logic [3:0] OP_DIV   = 4'd14;
`endif

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t state;
    state_t nxt;

    logic             acc;
    logic             bz;
    logic             go_mul;
    logic             go_div;
    logic             dz_now;
    logic             start;
    logic             last;
    logic [SHW-1:0]   cnt;
    logic             is_div;
    logic [WIDTH-1:0] wh;
    logic [WIDTH-1:0] wl;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic             ovf;

    logic [WIDTH-1:0] res;
    logic             s_cf;
    logic             s_of;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   sll_w;
    logic [WIDTH:0]   srl_w;
    logic [WIDTH:0]   sra_w;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_df;
    logic [WIDTH-1:0] it_h;
    logic [WIDTH-1:0] it_l;
    logic [WIDTH-1:0] fin_h;
    logic [WIDTH-1:0] fin_l;

    logic             upd;
    logic             wr_hl;
    logic [WIDTH-1:0] nf;
    logic [WIDTH-1:0] nhi;
    logic [WIDTH-1:0] nlo;
    logic             ncf;
    logic             nof;
    logic             ndz;

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    logic             sgn;
    logic             neg_lo;
    logic             neg_hi;
    logic             ovf_r;
    logic [2*WIDTH-1:0] prod;
`endif

    assign acc  = bus.in_valid & bus.in_ready;
    assign bz   = (bus.B == '0);
    assign last = (state == S_BUSY) &&
                  (cnt == SHW'(WIDTH - 1));

    // Decide which accepted ops go iterative
    always_comb begin
        go_mul = (bus.OP == OP_MULTU);
        go_div = (bus.OP == OP_DIVU) && !bz;
        dz_now = (bus.OP == OP_DIVU) && bz;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        go_mul = go_mul || (bus.OP == OP_MULT);
        go_div = go_div ||
                 ((bus.OP == OP_DIV) && !bz);
        dz_now = dz_now ||
                 ((bus.OP == OP_DIV) && bz);
`endif
        start = acc && (go_mul || go_div);
    end

    always_comb begin
        ma = bus.A;
        mb = bus.B;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        sgn = (bus.OP == OP_MULT) ||
              (bus.OP == OP_DIV);
        if (sgn && bus.A[WIDTH-1]) ma = -bus.A;
        if (sgn && bus.B[WIDTH-1]) mb = -bus.B;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (start) nxt = S_BUSY;
            S_BUSY: if (last)  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == S_IDLE);
    end

    always_comb begin
        ext   = '0;
        sll_w = {1'b0, bus.B} << bus.A[SHW-1:0];
        srl_w = {bus.B, 1'b0} >> bus.A[SHW-1:0];
        sra_w = $signed({bus.B, 1'b0}) >>>
                bus.A[SHW-1:0];
        res   = '0;
        s_cf  = 1'b0;
        s_of  = 1'b0;
        case (bus.OP)
            OP_AND: res = bus.A & bus.B;
            OP_OR:  res = bus.A | bus.B;
            OP_XOR: res = bus.A ^ bus.B;
            OP_NOR: res = ~(bus.A | bus.B);
            OP_ADD: begin
                ext  = {1'b0, bus.A} + {1'b0, bus.B};
                res  = ext[WIDTH-1:0];
                s_cf = ext[WIDTH];
                s_of = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                       (res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                ext  = {1'b0, bus.A} - {1'b0, bus.B};
                res  = ext[WIDTH-1:0];
                s_cf = ext[WIDTH];
                s_of = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                       (res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT: res = WIDTH'($signed(bus.A) <
                                 $signed(bus.B));
            OP_SLTU: res = WIDTH'(bus.A < bus.B);
            // The extra bit catches the last bit shifted out
            OP_SLL: begin
                res  = sll_w[WIDTH-1:0];
                s_cf = sll_w[WIDTH];
            end
            OP_SRL: begin
                res  = srl_w[WIDTH:1];
                s_cf = srl_w[0];
            end
            OP_SRA: begin
                res  = sra_w[WIDTH:1];
                s_cf = sra_w[0];
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        mul_sum = {1'b0, wh} +
                  (wl[0] ? {1'b0, wd} : '0);
        div_sh  = {wh, wl[WIDTH-1]};
        div_df  = div_sh - {1'b0, wd};
        if (is_div) begin
            it_h = div_df[WIDTH] ? div_sh[WIDTH-1:0]
                                 : div_df[WIDTH-1:0];
            it_l = {wl[WIDTH-2:0], ~div_df[WIDTH]};
        end else begin
            it_h = mul_sum[WIDTH:1];
            it_l = {mul_sum[0], wl[WIDTH-1:1]};
        end
    end

    always_comb begin
        fin_h = it_h;
        fin_l = it_l;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
        prod = {it_h, it_l};
        if (!is_div && neg_lo) begin
            prod  = -prod;
            fin_h = prod[2*WIDTH-1:WIDTH];
            fin_l = prod[WIDTH-1:0];
        end
        if (is_div && neg_lo) fin_l = -it_l;
        if (is_div && neg_hi) fin_h = -it_h;
        ovf = ovf_r;
`else
        ovf = 1'b0;
`endif
    end

    always_comb begin
        upd   = 1'b0;
        wr_hl = 1'b0;
        nf    = res;
        nhi   = bus.HI;
        nlo   = bus.LO;
        ncf   = s_cf;
        nof   = s_of;
        ndz   = 1'b0;
        if (last) begin
            upd   = 1'b1;
            wr_hl = 1'b1;
            nhi   = fin_h;
            nlo   = fin_l;
            nf    = fin_l;
            ncf   = 1'b0;
            nof   = ovf;
        end else if (acc && dz_now) begin
            upd   = 1'b1;
            wr_hl = 1'b1;
            nhi   = bus.A;
            nlo   = '1;
            nf    = '1;
            ncf   = 1'b0;
            nof   = 1'b0;
            ndz   = 1'b1;
        end else if (acc && !start) begin
            upd = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.F  <= '0;
            bus.HI <= '0;
            bus.LO <= '0;
            bus.ZF <= 1'b0;
            bus.CF <= 1'b0;
            bus.OF <= 1'b0;
            bus.SF <= 1'b0;
            bus.PF <= 1'b0;
            bus.DZ <= 1'b0;
        end else begin
            bus.out_valid <= upd;
            if (upd) begin
                bus.F  <= nf;
                bus.ZF <= (nf == '0);
                bus.SF <= nf[WIDTH-1];
                bus.PF <= ^nf;
                bus.CF <= ncf;
                bus.OF <= nof;
                bus.DZ <= ndz;
            end
            if (wr_hl) begin
                bus.HI <= nhi;
                bus.LO <= nlo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            wh     <= '0;
            wl     <= '0;
            wd     <= '0;
        end else if (start) begin
            cnt    <= '0;
            is_div <= go_div;
            wh     <= '0;
            wl     <= go_div ? ma : mb;
            wd     <= go_div ? mb : ma;
        end else if (state == S_BUSY) begin
            cnt <= cnt + SHW'(1);
            wh  <= it_h;
            wl  <= it_l;
        end
    end

`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    // Sign fix-ups latched at accept; the core sees magnitudes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (start) begin
            neg_lo <= sgn &&
                      (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_hi <= sgn && go_div && bus.A[WIDTH-1];
            ovf_r  <= (bus.OP == OP_DIV) &&
                      (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.B == '1);
        end
    end
`endif
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational 32-bit ALU.
- Registers every result and flag. Adds right shifts, an unsigned compare, and iterative unsigned multiply/divide into HI/LO.
- Sits in the EX stage. Uses a valid/ready handshake so multi-cycle ops can stall the pipeline.

Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH): shift-amount bits taken from A.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- OP  input  4  opcode (below).
- A  input  WIDTH  operand A; shift amount = A[SHW-1:0].
- B  input  WIDTH  operand B; the value shifted.
- out_valid  output  1  one-cycle pulse: F/HI/LO/flags updated.
- F  output  WIDTH  result (LO copy for MUL/DIV).
- HI  output  WIDTH  product high half / remainder.
- LO  output  WIDTH  product low half / quotient.
- ZF, CF, OF, SF, PF  output  1 each  registered flags.
- DZ  output  1  divide-by-zero on last DIV.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB.
  - 6 SLT (signed), 7 SLL, 8 SRL, 9 SRA, 10 SLTU.
  - 11 MULTU, 12 DIVU, 13 MULT, 14 DIV.
  - 15 reserved: treated as a single-cycle op, F=0.
- Reset (async, rst_n low): state IDLE; in_ready=1; out_valid=0; F, HI, LO=0; all flags and DZ=0.
- FSM states: IDLE, BUSY.
- Accept: in_valid & in_ready at a rising edge (E0).
- Single-cycle ops (0-10, 15):
  - F and flags are registered at E0; out_valid=1 for the following cycle.
  - State stays IDLE and in_ready stays 1, giving 1 op/cycle throughput.
  - HI/LO hold their values.
- Arithmetic and flags:
  - ADD: {CF,F}=A+B; OF=signed overflow.
  - SUB: {CF,F}=A-B, CF=borrow; OF=signed overflow.
  - Logic/SLT/SLTU: CF=OF=0.
  - Shifts: CF=last bit shifted out, 0 if amount=0; OF=0; SRA sign-fills.
  - All ops: ZF=(F==0), SF=F[WIDTH-1], PF=^F.
- MULTU/DIVU:
  - On accept, latch operands; go to BUSY; in_ready=0.
  - One iteration per edge, E1..E_WIDTH: shift-add multiply, restoring divide.
  - At E_WIDTH: HI/LO/F written, out_valid=1 for one cycle, state returns to IDLE, in_ready=1. A new op may be accepted in that same cycle.
  - Latency is WIDTH cycles.
  - Flags: ZF/SF/PF from F=LO; CF=OF=0.
- DIVU with B=0:
  - No BUSY phase; completes like a single-cycle op.
  - LO=all ones, HI=A, F=LO, DZ=1.
  - DZ is cleared by any other completed op.
- in_valid while BUSY: ignored, not queued.
- OP/A/B changes while BUSY: no effect.
- out_valid carries no backpressure; the consumer must sample it.
- Reset mid-BUSY: the operation is aborted with no out_valid pulse. All outputs take reset values, and in_ready=1 from the first edge after rst_n deasserts.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_MULDIV_EN.
- Defined:
  - OP 13 MULT and OP 14 DIV work in two's complement. Operands are converted to magnitudes, the unsigned core is reused, and the results are negated at the end.
  - Remainder sign follows A. Latency is WIDTH cycles.
  - DIV by 0 follows the DIVU rule (LO=all ones, HI=A, DZ=1).
  - DIV of the most-negative value by -1 gives LO=most-negative, HI=0, and OF=1.
- Undefined:
  - OP 13/14 behave as reserved: single cycle, F=0, HI/LO unchanged, ZF=1.

Test Plan (WIDTH=32):
- ADD A=0x7FFFFFFF, B=1 -> next cycle out_valid=1; F=0x80000000, OF=1, CF=0, SF=1, ZF=0, PF=1.
- SUB A=5, B=7, immediately followed by SLL A=4, B=0x90000001 on the next cycle:
  - First result: F=0xFFFFFFFE, CF=1, SF=1.
  - Second result, one cycle later: F=0x00000010, CF=1.
  - in_ready stays 1 throughout.
- MULTU A=0xFFFFFFFF, B=2 -> in_ready=0 for 32 cycles; out_valid exactly 32 cycles after accept; HI=1, LO=0xFFFFFFFE; in_valid during BUSY ignored.
- DIVU 100/7 -> LO=14, HI=2, DZ=0. Then DIVU 0x1234/0 -> next cycle LO=0xFFFFFFFF, HI=0x1234, DZ=1.
- Reset mid-operation: rst_n low 10 cycles into a MULTU -> no out_valid pulse; HI=LO=F=0; in_ready=1. A subsequent AND 0xF0F0/0x0FF0 -> F=0x00F0.
- With SEQ_ALU_SIGNED_MULDIV_EN:
  - MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Without the macro: OP 13 -> F=0, ZF=1 after 1 cycle.
